ysyx_22041752_div_iter: RTL and testbench

- Iterative radix-2 restoring divider that answers div/rem requests from the execute stage through a valid/ready request channel and a valid/ready response channel.
- It is the multi-cycle, handshake-driven counterpart of the ALU's combinational divide path.
- It supports RV64M DIV/DIVU/REM/REMU and the word forms DIVW/DIVUW/REMW/REMUW.
- Both quotient and remainder are produced per request; the requester selects which one to use.

---
 rtl/ysyx_22041752_div_iter.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_22041752_div_iter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_div_iter.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and word forms, valid/ready on both sides.
// The first shift/subtract step runs on the accept edge, so an N-bit divide completes on the N-th edge counting the accept edge.
module ysyx_22041752_div_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            div_valid,
  output logic            div_ready,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic [XLEN-1:0] div_x,
  input  logic [XLEN-1:0] div_y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_quot,
  output logic [XLEN-1:0] out_rem
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic            word_q, word_d;
  logic [XLEN-1:0] res_quot_q, res_quot_d;
  logic [XLEN-1:0] res_rem_q, res_rem_d;

  logic [XLEN-1:0] eff_x, eff_y, mag_x, mag_y, min_neg;
  logic            sign_x, sign_y, div_zero, ovf, accept;
  logic [XLEN-1:0] step_rem_in, step_quot_in, step_dvs, step_rem, step_quot;
  logic [XLEN:0]   shifted;
  logic            no_borrow;
  logic [XLEN-1:0] fin_quot, fin_rem, sp_quot, sp_rem;

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic word);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign div_ready = ready_q & ~flush;
  assign accept    = div_valid & div_ready;
  assign out_valid = valid_q;
  assign out_quot  = res_quot_q;
  assign out_rem   = res_rem_q;

  always_comb begin
    if (div_word) begin
      eff_x = {{(XLEN-32){div_signed & div_x[31]}}, div_x[31:0]};
      eff_y = {{(XLEN-32){div_signed & div_y[31]}}, div_y[31:0]};
      min_neg = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      eff_x = div_x;
      eff_y = div_y;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end
    sign_x   = div_signed & eff_x[XLEN-1];
    sign_y   = div_signed & eff_y[XLEN-1];
    mag_x    = sign_x ? -eff_x : eff_x;
    mag_y    = sign_y ? -eff_y : eff_y;
    div_zero = (eff_y == '0);
    ovf      = div_signed & (eff_x == min_neg) & (&eff_y);
    sp_quot  = word_ext(div_zero ? '1 : eff_x, div_word);
    sp_rem   = word_ext(div_zero ? eff_x : '0, div_word);
  end

  // Word operands sit in the upper half so the 32 shifts leave the quotient in bits [31:0].
  always_comb begin
    if (state_q == IDLE) begin
      step_rem_in  = '0;
      step_quot_in = div_word ? {mag_x[31:0], {(XLEN-32){1'b0}}} : mag_x;
      step_dvs     = mag_y;
    end else begin
      step_rem_in  = rem_q;
      step_quot_in = quot_q;
      step_dvs     = dvs_q;
    end
    shifted   = {step_rem_in, step_quot_in[XLEN-1]};
    no_borrow = (shifted >= {1'b0, step_dvs});
    step_rem  = no_borrow ? XLEN'(shifted - {1'b0, step_dvs}) : shifted[XLEN-1:0];
    step_quot = {step_quot_in[XLEN-2:0], no_borrow};
    fin_quot  = word_ext(neg_quot_q ? -step_quot : step_quot, word_q);
    fin_rem   = word_ext(neg_rem_q ? -step_rem : step_rem, word_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    valid_d    = valid_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    word_d     = word_q;
    res_quot_d = res_quot_q;
    res_rem_d  = res_rem_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          neg_quot_d = sign_x ^ sign_y;
          neg_rem_d  = sign_x;
          word_d     = div_word;
          ready_d    = 1'b0;
          if (div_zero || ovf) begin
            state_d    = DONE;
            valid_d    = 1'b1;
            res_quot_d = sp_quot;
            res_rem_d  = sp_rem;
          end else begin
            state_d = BUSY;
            cnt_d   = div_word ? CW'(32) : CW'(XLEN);
            rem_d   = step_rem;
            quot_d  = step_quot;
            dvs_d   = mag_y;
          end
        end
      end
      BUSY: begin
        rem_d  = step_rem;
        quot_d = step_quot;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(2)) begin
          state_d    = DONE;
          valid_d    = 1'b1;
          res_quot_d = fin_quot;
          res_rem_d  = fin_rem;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
        cnt_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = IDLE;
      valid_d = 1'b0;
      ready_d = 1'b1;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      word_q     <= 1'b0;
      res_quot_q <= '0;
      res_rem_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      word_q     <= word_d;
      res_quot_q <= res_quot_d;
      res_rem_q  <= res_rem_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041752_div_iter.sv
// Self-checking bench for ysyx_22041752_div_iter: directed and random divides scored against a RISC-V reference model.
// Latency counts clock edges from the accept edge (inclusive) to the first edge after which out_valid is high.
module tb_ysyx_22041752_div_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic        div_signed = 1'b0;
  logic        div_word = 1'b0;
  logic [63:0] div_x = '0;
  logic [63:0] div_y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_quot;
  logic [63:0] out_rem;

  typedef struct {
    logic [63:0] quot;
    logic [63:0] rem;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  ysyx_22041752_div_iter #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .div_valid(div_valid), .div_ready(div_ready),
    .div_signed(div_signed), .div_word(div_word),
    .div_x(div_x), .div_y(div_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [63:0] x, input logic [63:0] y, input bit s, input bit w,
                                output logic [63:0] q, output logic [63:0] r, output int lat);
    logic [31:0] xu32, yu32, q32, r32;
    logic signed [31:0] xs32, ys32;
    logic signed [63:0] xs64, ys64;
    if (w) begin
      xu32 = x[31:0];
      yu32 = y[31:0];
      xs32 = x[31:0];
      ys32 = y[31:0];
      lat  = 32;
      if (yu32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = xu32; lat = 1;
      end else if (s && xu32 == 32'h8000_0000 && yu32 == 32'hFFFF_FFFF) begin
        q32 = xu32; r32 = 32'd0; lat = 1;
      end else if (s) begin
        q32 = xs32 / ys32; r32 = xs32 % ys32;
      end else begin
        q32 = xu32 / yu32; r32 = xu32 % yu32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      xs64 = x;
      ys64 = y;
      lat  = 64;
      if (y == 64'd0) begin
        q = '1; r = x; lat = 1;
      end else if (s && x == 64'h8000_0000_0000_0000 && y == '1) begin
        q = x; r = '0; lat = 1;
      end else if (s) begin
        q = xs64 / ys64; r = xs64 % ys64;
      end else begin
        q = x / y; r = x % y;
      end
    end
  endfunction

  task automatic driveReq(input logic [63:0] x, input logic [63:0] y, input bit s, input bit w, input bit push);
    exp_t e;
    div_x = x; div_y = y; div_signed = s; div_word = w; div_valid = 1'b1;
    if (push) begin
      model(x, y, s, w, e.quot, e.rem, e.lat);
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge, div_valid still high.
  task automatic waitAccept();
    int n = 0;
    while (!div_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {63'd0, div_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [63:0] x, input logic [63:0] y, input bit s, input bit w, input bit push);
    driveReq(x, y, s, w, push);
    waitAccept();
    div_valid = 1'b0;
  endtask

  task automatic checkOutput(input int hold);
    exp_t e;
    int lat = 1;
    logic keep_ready;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid", {63'd0, out_valid}, 64'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      check("latency", 64'(lat), 64'(e.lat));
      check("quot", out_quot, e.quot);
      check("rem", out_rem, e.rem);
      check("ready_in_done", {63'd0, div_ready}, 64'd0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_quot", out_quot, e.quot);
        check("hold_rem", out_rem, e.rem);
        check("hold_ready", {63'd0, div_ready}, 64'd0);
      end
    end
    keep_ready = out_ready;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = keep_ready;
    check("valid_after_ack", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int seen;
    logic [63:0] rx, ry;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", {63'd0, div_ready}, 64'd1);
    check("reset_valid", {63'd0, out_valid}, 64'd0);
    check("reset_quot", out_quot, 64'd0);
    check("reset_rem", out_rem, 64'd0);

    applyStimulus(64'd100, 64'd7, 1'b0, 1'b0, 1'b1);
    checkOutput(5);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b1);
    checkOutput(0);

    applyStimulus(64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    checkOutput(0);

    applyStimulus(64'h1234, 64'd0, 1'b0, 1'b0, 1'b1);
    checkOutput(0);

    applyStimulus(64'h0000_0000_8000_0000, 64'd0, 1'b0, 1'b1, 1'b1);
    checkOutput(0);

    applyStimulus(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    checkOutput(0);

    applyStimulus(64'h0000_0000_FFFF_FF9C, 64'd7, 1'b1, 1'b1, 1'b1);
    checkOutput(0);

    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b1);
    checkOutput(0);

    // Flush part-way through the divide: the request must vanish without a response.
    applyStimulus(64'd1000, 64'd3, 1'b0, 1'b0, 1'b0);
    repeat (18) @(negedge clk);
    flush = 1'b1;
    #1 check("flush_ready_low", {63'd0, div_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_ready_back", {63'd0, div_ready}, 64'd1);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_output", 64'(seen), 64'd0);

    applyStimulus(64'd9, 64'd4, 1'b0, 1'b0, 1'b1);
    checkOutput(0);

    // Flush together with a request in IDLE must not accept it.
    driveReq(64'd5, 64'd1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1 check("flush_idle_ready", {63'd0, div_ready}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    div_valid = 1'b0;
    #1 check("flush_idle_no_accept", {63'd0, div_ready}, 64'd1);

    // Back-to-back with div_valid held high and out_ready high.
    @(negedge clk);
    out_ready = 1'b1;
    driveReq(64'd77, 64'd5, 1'b0, 1'b0, 1'b1);
    waitAccept();
    driveReq(64'hFFFF_FFFF_FFFF_FF00, 64'd3, 1'b1, 1'b0, 1'b1);
    checkOutput(0);
    waitAccept();
    div_valid = 1'b0;
    checkOutput(0);
    out_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      rx = {$urandom, $urandom};
      ry = {$urandom, $urandom} >> $urandom_range(0, 62);
      applyStimulus(rx, ry, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      checkOutput(0);
    end

    // Asynchronous reset in the middle of a divide.
    applyStimulus(64'd123456789, 64'd11, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("areset_valid", {63'd0, out_valid}, 64'd0);
    check("areset_quot", out_quot, 64'd0);
    check("areset_rem", out_rem, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_ready", {63'd0, div_ready}, 64'd1);
    check("after_reset_valid", {63'd0, out_valid}, 64'd0);

    applyStimulus(64'd50, 64'd6, 1'b0, 1'b1, 1'b1);
    checkOutput(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
